// File: rtl/cmult_arbiter.sv
// ----------------------------------------------------------------------------
// cmult_arbiter
//   Round-robin arbiter that shares one pipelined complex multiplier (fixed
//   LATENCY) between NUM_REQ requesters. One operand pair per cycle is
//   registered into the multiplier. A tag pipe carries the requester ID
//   alongside the multiplier pipe so that each result can be routed back to
//   its requester. A drain/quiesce sequence stops issuing and empties the pipe
//   at frame boundaries.
//
// Build option:
//   CMULT_ARB_STATS_EN : when defined, adds o_issue_cnt, a 16-bit wrapping
//                        transfer counter per requester. The counters clear on
//                        reset and on entry to DRAINED.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req_valid         per-requester operand valid
//   o_req_ready         one-hot grant (combinational, RUN state only)
//   i_req_a, i_req_b    operands, requester i at slice i ({re,im} each)
//   o_m_valid/a/b       registered issue to the multiplier
//   i_m_o_valid, i_m_c  multiplier result
//   o_rsp_valid         one-hot result strobe (no backpressure)
//   o_rsp_data          registered result shared by all requesters
//   i_drain             level request to stop issuing and empty the pipe
//   o_drain_done        high while DRAINED
//   o_busy              results still in flight
//   o_tag_err           sticky: multiplier valid disagreed with the tag pipe
//   o_issue_cnt         (CMULT_ARB_STATS_EN only) per-requester transfer counts
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_RUN      | arbitrating, one transfer per cycle allowed
// S_DRAIN    | issue stopped, waiting for in-flight results to return
// S_DRAINED  | pipe empty, held until drain is released
// ----------------------------------------------------------------------------
module cmult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int word_size = 16,
  parameter int LATENCY   = 3,
  parameter int ID_W      = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*2*word_size-1:0]   i_req_a,
  input  logic [NUM_REQ*2*word_size-1:0]   i_req_b,
  output logic                             o_m_valid,
  output logic [2*word_size-1:0]           o_m_a,
  output logic [2*word_size-1:0]           o_m_b,
  input  logic                             i_m_o_valid,
  input  logic [2*word_size-1:0]           i_m_c,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [2*word_size-1:0]           o_rsp_data,
  input  logic                             i_drain,
  output logic                             o_drain_done,
  output logic                             o_busy,
  output logic                             o_tag_err
`ifdef CMULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]            o_issue_cnt
`endif
);

  localparam int DW = 2 * word_size;
  // in-flight range is 0..LATENCY+2
  localparam int CNT_W = $clog2(LATENCY + 3);
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_DRAINED = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_inflight;
  logic                r_tag_v  [LATENCY+1];
  logic [ID_W-1:0]     r_tag_id [LATENCY+1];
  logic                r_m_valid;
  logic [DW-1:0]       r_m_a;
  logic [DW-1:0]       r_m_b;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DW-1:0]       r_rsp_data;
  logic                r_drain_done;
  logic                r_tag_err;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic                 w_found;
  logic [ID_W-1:0]      w_grant_id;
  logic [ID_W:0]        w_sum;
  logic [ID_W:0]        w_nxt_sum;
  logic [ID_W-1:0]      w_nxt_ptr;
  logic                 w_xfer;
  logic [DW-1:0]        w_sel_a;
  logic [DW-1:0]        w_sel_b;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr; the
  // first set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_req_dbl  = {i_req_valid, i_req_valid};
    w_req_rot  = w_req_dbl[r_rr_ptr +: NUM_REQ];
    w_found    = 1'b0;
    w_grant_id = '0;
    w_sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
        if (w_sum >= NUM_REQ_W) begin
          w_sum = w_sum - NUM_REQ_W;
        end
        w_grant_id = w_sum[ID_W-1:0];
      end
    end
  end

  assign w_xfer      = w_found && (r_state == S_RUN) && !i_reset;
  assign o_req_ready = w_xfer ? (NUM_REQ'(1) << w_grant_id) : '0;

  always_comb begin
    w_nxt_sum = {1'b0, w_grant_id} + (ID_W + 1)'(1);
    w_nxt_ptr = (w_nxt_sum >= NUM_REQ_W) ? '0 : w_nxt_sum[ID_W-1:0];
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_a = i_req_a[i*DW +: DW];
        w_sel_b = i_req_b[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_RUN;
      r_rr_ptr     <= '0;
      r_inflight   <= '0;
      r_m_valid    <= 1'b0;
      r_m_a        <= '0;
      r_m_b        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_drain_done <= 1'b0;
      r_tag_err    <= 1'b0;
      for (int j = 0; j <= LATENCY; j++) begin
        r_tag_v[j]  <= 1'b0;
        r_tag_id[j] <= '0;
      end
    end else begin
      r_m_valid <= w_xfer;
      if (w_xfer) begin
        r_m_a    <= w_sel_a;
        r_m_b    <= w_sel_b;
        r_rr_ptr <= w_nxt_ptr;
      end

      // Stage 0 travels with m_valid; stage LATENCY lines up with m_o_valid.
      r_tag_v[0]  <= w_xfer;
      r_tag_id[0] <= w_grant_id;
      for (int j = 1; j <= LATENCY; j++) begin
        r_tag_v[j]  <= r_tag_v[j-1];
        r_tag_id[j] <= r_tag_id[j-1];
      end

      // Routing follows the tag, not m_o_valid, so a spurious multiplier
      // strobe can never produce a response or upset the in-flight count.
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= r_tag_v[LATENCY] && (r_tag_id[LATENCY] == ID_W'(i));
      end
      if (r_tag_v[LATENCY]) begin
        r_rsp_data <= i_m_c;
      end

      if (i_m_o_valid != r_tag_v[LATENCY]) begin
        r_tag_err <= 1'b1;
      end

      case ({w_xfer, |r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      case (r_state)
        S_RUN: begin
          if (i_drain) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!i_drain) begin
            r_state <= S_RUN;
          end else if (r_inflight == '0) begin
            r_state      <= S_DRAINED;
            r_drain_done <= 1'b1;
          end
        end
        S_DRAINED: begin
          if (!i_drain) begin
            r_state      <= S_RUN;
            r_drain_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_RUN;
          r_drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_m_valid    = r_m_valid;
  assign o_m_a        = r_m_a;
  assign o_m_b        = r_m_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_drain_done = r_drain_done;
  assign o_busy       = (r_inflight != '0);
  assign o_tag_err    = r_tag_err;

`ifdef CMULT_ARB_STATS_EN
  logic [15:0] r_issue_cnt [NUM_REQ];
  logic        w_enter_drained;

  assign w_enter_drained = (r_state == S_DRAIN) && i_drain && (r_inflight == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_enter_drained) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_issue_cnt[i] <= '0;
      end
    end else if (w_xfer) begin
      r_issue_cnt[w_grant_id] <= r_issue_cnt[w_grant_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign o_issue_cnt[g*16 +: 16] = r_issue_cnt[g];
  end
`endif

endmodule
